// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - switch/button front end that loads A, B and opcode into the ALU and latches its flags
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   sw[N-1:0]                     data switches; sw[3:0] doubles as the operation code
//   btn_next, btn_clear           raw, bouncing, asynchronous push buttons (active-high)
//   a, b, operation               registered command driven to the combinational ALU
//   valid                         command complete (state EXEC)
//   inFlagC/N/V/Z                 flags returned by the ALU
//   flags_q, flags_valid          latched {C,N,V,Z} and its qualifier
//   state                         current step, for the board LEDs
//   err                           last opcode entry was rejected
module alu_operand_loader #(
    parameter int N         = 4,
    parameter int DB_CYCLES = 250000,
    parameter int OP_MAX    = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    input  logic         btn_next,
    input  logic         btn_clear,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [3:0]   operation,
    output logic         valid,
    input  logic         inFlagC,
    input  logic         inFlagN,
    input  logic         inFlagV,
    input  logic         inFlagZ,
    output logic [3:0]   flags_q,
    output logic         flags_valid,
    output logic [1:0]   state,
    output logic         err
);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_EXEC = 2'd3
    } state_t;

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);

    // ------------------------------------------------------------------
    // Button conditioning. Bit 0 is the step button, bit 1 is clear.
    // ------------------------------------------------------------------
    logic [1:0]    raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    last_q;     // sync2 delayed one cycle, used to spot level changes
    logic [1:0]    filt_q;     // debounced level
    logic [1:0]    filt_dly_q; // previous debounced level, for edge detection
    logic [CW-1:0] cnt_q [2];
    logic [1:0]    pulse;
    logic          next_p;
    logic          clear_p;

    assign raw = {btn_clear, btn_next};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            last_q     <= 2'b00;
            filt_q     <= 2'b00;
            filt_dly_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            last_q     <= sync2_q;
            filt_dly_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                // Any change restarts the stability window; otherwise count up
                // and park at the threshold.
                if (sync2_q[i] != last_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] != DB_MAX) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
                // last_q has been unchanged for the whole window here.
                if (cnt_q[i] == DB_MAX) begin
                    filt_q[i] <= last_q[i];
                end
            end
        end
    end

    assign pulse   = filt_q & ~filt_dly_q;
    assign next_p  = pulse[0];
    assign clear_p = pulse[1];

    // ------------------------------------------------------------------
    // Command sequencer
    // ------------------------------------------------------------------
    state_t       state_q;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [3:0]   op_q;
    logic         valid_q;
    logic [3:0]   flg_q;
    logic         flg_valid_q;
    logic         err_q;
    logic         op_legal;

    assign op_legal = (32'(sw[3:0]) <= OP_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_A;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 4'h0;
            valid_q     <= 1'b0;
            flg_q       <= 4'h0;
            flg_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (clear_p) begin
            // Clear beats a simultaneous step press.
            state_q     <= S_A;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 4'h0;
            valid_q     <= 1'b0;
            flg_q       <= 4'h0;
            flg_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_A: begin
                    if (next_p) begin
                        a_q     <= sw;
                        state_q <= S_B;
                    end
                end
                S_B: begin
                    if (next_p) begin
                        b_q     <= sw;
                        state_q <= S_OP;
                    end
                end
                S_OP: begin
                    if (next_p) begin
                        if (op_legal) begin
                            op_q    <= sw[3:0];
                            err_q   <= 1'b0;
                            valid_q <= 1'b1;
                            state_q <= S_EXEC;
                        end else begin
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (next_p) begin
                        state_q     <= S_A;
                        valid_q     <= 1'b0;
                        flg_valid_q <= 1'b0;
                    end else if (!flg_valid_q) begin
                        // First EXEC cycle: the ALU inputs have been stable for a
                        // full cycle, so its combinational flags are settled.
                        flg_q       <= {inFlagC, inFlagN, inFlagV, inFlagZ};
                        flg_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_A;
                end
            endcase
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign operation   = op_q;
    assign valid       = valid_q;
    assign flags_q     = flg_q;
    assign flags_valid = flg_valid_q;
    assign state       = state_q;
    assign err         = err_q;

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Sequential front end for the combinational ALU: it collects operand A, operand B and the 4-bit operation code from the board switches over a sequence of debounced button presses, and presents them to the ALU. It then latches the C/N/V/Z flags the ALU returns. It is the initiator side of the ALU's a/b/operation → flags interface and replaces direct switch wiring on the board top level.

## Interface
Parameters:
- N, 4, operand width in bits; N ≥ 4.
- DB_CYCLES, 250000, consecutive stable cycles needed to accept a button level (5 ms at 50 MHz).
- OP_MAX, 10, highest legal operation code; codes above it are rejected.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sw  in  N  data switches; sw[3:0] also supplies the operation code.
- btn_next  in  1  raw step button, active-high, asynchronous to clk.
- btn_clear  in  1  raw clear button, active-high, asynchronous to clk.
- a  out  N  registered operand A to the ALU.
- b  out  N  registered operand B to the ALU.
- operation  out  4  registered operation code to the ALU.
- valid  out  1  high while a, b and operation form a complete command (state EXEC).
- inFlagC, inFlagN, inFlagV, inFlagZ  in  1 each  flags returned by the ALU.
- flags_q  out  4  latched flags {C,N,V,Z}.
- flags_valid  out  1  high when flags_q holds the result of the current command.
- state  out  2  current state, for the board LEDs.
- err  out  1  high after an illegal opcode was rejected.

## Operation
- Each button path: 2-flop synchronizer, then a stable-level counter. The counter loads 0 on any change of the synchronized level and saturates at DB_CYCLES. The filtered level updates only when the counter reaches DB_CYCLES. A rising edge of the filtered level produces a one-cycle pulse (next_p / clear_p).
- States and encodings: S_A=0, S_B=1, S_OP=2, S_EXEC=3. Reset state is S_A.
- S_A: on next_p, a ← sw and go to S_B.
- S_B: on next_p, b ← sw and go to S_OP.
- S_OP: on next_p:
  - If sw[3:0] ≤ OP_MAX: operation ← sw[3:0], err ← 0, go to S_EXEC.
  - Otherwise: stay in S_OP, set err to 1, leave operation unchanged.
- S_EXEC: valid=1. On next_p, go to S_A and clear valid and flags_valid. a, b and operation keep their values until they are overwritten by a new capture.
- clear_p in any state: go to S_A and clear a, b, operation, flags_q, flags_valid and err. When clear_p and next_p occur in the same cycle, clear wins.
- Flag capture: on the first cycle in S_EXEC, flags_q ← {inFlagC,inFlagN,inFlagV,inFlagZ} and flags_valid ← 1. The ALU is purely combinational, so its inputs have been stable for one full cycle at that point. flags_q is then held until the next clear or the next exit from S_EXEC.
- Switches are sampled directly, without synchronization. The user holds them steady while pressing a button, and capture happens long after the button edge.

## Timing
- All outputs reset to 0 asynchronously: a, b, operation, valid, flags_q, flags_valid, err, state=S_A. Debounce counters and filtered levels also reset to 0.
- Press latency: the raw edge is followed by 2 synchronizer cycles plus DB_CYCLES stable cycles, then next_p. The register update lands on the edge after next_p.
- Bounces shorter than DB_CYCLES produce no pulse. A held button produces exactly one pulse. Release produces none.
- A reset asserted mid-sequence returns to S_A immediately, without waiting for a clock edge.
- valid rises together with the operation update. flags_valid rises exactly 1 cycle after valid.
- Maximum one state transition per cycle.

## Test plan
Run with DB_CYCLES=4, N=4.
1. Reset check. Assert rst mid-cycle → all outputs are 0 and state=0 before the next edge.
2. Full sequence with sw=3, 5, 0 and clean presses → a=3, b=5, operation=0, valid=1. flags_valid=1 one cycle later. flags_q equals the inputs driven by the ALU model (ADD 3+5=8: C=0, N=1, V=1, Z=0).
3. Bounce rejection. Toggle btn_next every 2 cycles for 20 cycles, then hold it → exactly one pulse, exactly one state advance, and the state holds while the button stays high.
4. Illegal opcode. In S_OP with sw=4'hB → state stays 2, err=1, operation unchanged. Then sw=4'h2 plus a press → state 3, err=0.
5. Clear priority. next_p and clear_p arrive in the same cycle while in S_B → state 0, and a, b, operation and flags are all 0.
6. Repeat command. From S_EXEC, press next → state 0, valid=0, flags_valid=0, and a, b and operation are retained. A second full sequence with sw=F, F, 1 → a=F, b=F, operation=1, with new flags latched.
